// File: rtl/done_barrier.sv
// done_barrier: collects per-lane completion pulses into sticky bits and
// raises a held "all done" handshake once every participating lane has
// reported. It also flags duplicate or out-of-round pulses (overrun) and
// rounds that run longer than a programmable cycle limit (timeout).
module done_barrier #(
    parameter int LENGTH    = 8,
    parameter int TIMEOUT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic [LENGTH-1:0]    lane_mask,
    input  logic [LENGTH-1:0]    lane_done,
    output logic [LENGTH-1:0]    pending,
    output logic                 all_valid,
    input  logic                 all_ready,
    output logic                 overrun,
    input  logic [TIMEOUT_W-1:0] timeout_limit,
    output logic                 timeout
);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t               state_r;
    logic [TIMEOUT_W-1:0] count_r;

    logic [LENGTH-1:0]    pending_next_s;
    logic [LENGTH-1:0]    eff_s;
    logic                 complete_s;
    logic                 dup_s;
    logic [TIMEOUT_W-1:0] count_inc_s;
    logic                 limit_on_s;
    logic                 at_limit_s;
    logic                 hit_next_s;

    // Next sticky vector, duplicate detection and the masked AND chain.
    always_comb begin
        pending_next_s = pending | lane_done;
        dup_s          = |(lane_done & pending);
        eff_s          = pending_next_s | ~lane_mask;
        complete_s     = 1'b1;
        for (int i = 0; i < LENGTH; i++) begin
            complete_s = complete_s & eff_s[i];
        end
    end

    // Timeout counter helpers: saturate at the limit (or at all-ones when
    // the timeout is disabled) so the counter never wraps.
    always_comb begin
        count_inc_s = count_r + TIMEOUT_W'(1);
        limit_on_s  = (timeout_limit != {TIMEOUT_W{1'b0}});
        if (limit_on_s) begin
            at_limit_s = (count_r == timeout_limit);
            hit_next_s = at_limit_s || (count_inc_s == timeout_limit);
        end else begin
            at_limit_s = (count_r == {TIMEOUT_W{1'b1}});
            hit_next_s = 1'b0;
        end
    end

    // Barrier state machine with all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= COLLECT;
            pending   <= {LENGTH{1'b0}};
            all_valid <= 1'b0;
            overrun   <= 1'b0;
            timeout   <= 1'b0;
            count_r   <= {TIMEOUT_W{1'b0}};
        end else if (clear) begin
            // Abort the round; overrun is intentionally kept.
            state_r   <= COLLECT;
            pending   <= {LENGTH{1'b0}};
            all_valid <= 1'b0;
            timeout   <= 1'b0;
            count_r   <= {TIMEOUT_W{1'b0}};
        end else begin
            case (state_r)
                COLLECT: begin
                    pending <= pending_next_s;
                    if (dup_s) begin
                        overrun <= 1'b1;
                    end
                    if (complete_s) begin
                        state_r   <= HOLD;
                        all_valid <= 1'b1;
                    end else begin
                        if (!at_limit_s) begin
                            count_r <= count_inc_s;
                        end
                        if (hit_next_s) begin
                            timeout <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // Pulses here belong to no round: flag and drop them.
                    if (lane_done != {LENGTH{1'b0}}) begin
                        overrun <= 1'b1;
                    end
                    if (all_ready) begin
                        state_r   <= COLLECT;
                        pending   <= {LENGTH{1'b0}};
                        all_valid <= 1'b0;
                        timeout   <= 1'b0;
                        count_r   <= {TIMEOUT_W{1'b0}};
                    end
                end
                default: begin
                    state_r   <= COLLECT;
                    pending   <= {LENGTH{1'b0}};
                    all_valid <= 1'b0;
                    timeout   <= 1'b0;
                    count_r   <= {TIMEOUT_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_done_barrier.sv
// Testbench for done_barrier: table-driven vectors, hand-written corner
// sequences and randomized traffic, all checked against a behavioural model.
module tb_done_barrier;

    localparam int LENGTH    = 8;
    localparam int TIMEOUT_W = 16;
    localparam int CNT_MAX   = 65535;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 clear;
    logic [LENGTH-1:0]    lane_mask;
    logic [LENGTH-1:0]    lane_done;
    logic [LENGTH-1:0]    pending;
    logic                 all_valid;
    logic                 all_ready;
    logic                 overrun;
    logic [TIMEOUT_W-1:0] timeout_limit;
    logic                 timeout;

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    bit       m_hold;
    bit [7:0] m_pend;
    bit       m_ovr;
    bit       m_to;
    int       m_cnt;

    done_barrier #(.LENGTH(LENGTH), .TIMEOUT_W(TIMEOUT_W)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .lane_mask(lane_mask),
        .lane_done(lane_done), .pending(pending), .all_valid(all_valid),
        .all_ready(all_ready), .overrun(overrun),
        .timeout_limit(timeout_limit), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of one clock edge, written from the barrier rules.
    task automatic model_edge();
        int lim;
        lim = int'(timeout_limit);
        if (!rst_n) begin
            m_hold = 0; m_pend = 0; m_ovr = 0; m_to = 0; m_cnt = 0;
        end else if (clear) begin
            m_hold = 0; m_pend = 0; m_to = 0; m_cnt = 0;
        end else if (m_hold) begin
            if (lane_done != 0) m_ovr = 1;
            if (all_ready) begin
                m_hold = 0; m_pend = 0; m_to = 0; m_cnt = 0;
            end
        end else begin
            if ((lane_done & m_pend) != 0) m_ovr = 1;
            m_pend = m_pend | lane_done;
            if ((m_pend | ~lane_mask) == 8'hFF) begin
                m_hold = 1;
            end else if (lim == 0) begin
                if (m_cnt < CNT_MAX) m_cnt++;
            end else begin
                if (m_cnt < lim) m_cnt++;
                if (m_cnt >= lim) m_to = 1;
            end
        end
    endtask

    // Advance one clock edge and compare every output against the model.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_pending", 32'(pending), 32'(m_pend));
        chk("model_all_valid", 32'(all_valid), 32'(m_hold));
        chk("model_overrun", 32'(overrun), 32'(m_ovr));
        chk("model_timeout", 32'(timeout), 32'(m_to));
    endtask

    task automatic drive(input logic r, input logic c, input logic [7:0] m,
                         input logic [7:0] d, input logic rdy);
        rst_n = r; clear = c; lane_mask = m; lane_done = d; all_ready = rdy;
    endtask

    typedef struct {
        logic       rst_n;
        logic       clr;
        logic [7:0] mask;
        logic [7:0] done;
        logic       rdy;
        logic [7:0] e_pend;
        logic       e_val;
        logic       e_ovr;
        logic       e_to;
    } vec_t;

    vec_t tbl[16];

    initial begin
        drive(1'b0, 1'b0, 8'hFF, 8'h00, 1'b0);
        timeout_limit = 16'd0;

        // Reset, in-order lanes, mask 0F, mask 00.
        tbl[0]  = '{1'b0, 1'b0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 8'hFF, 8'h02, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 8'hFF, 8'h04, 1'b1, 8'h07, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 8'hFF, 8'h08, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 8'hFF, 8'h10, 1'b1, 8'h1F, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 8'hFF, 8'h20, 1'b1, 8'h3F, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 8'hFF, 8'h40, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 8'hFF, 8'h80, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 8'h0F, 8'h0F, 1'b0, 8'h0F, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 8'h0F, 8'h00, 1'b0, 8'h0F, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 8'h0F, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].rst_n, tbl[i].clr, tbl[i].mask, tbl[i].done, tbl[i].rdy);
            step();
            chk($sformatf("tbl%0d_pending", i), 32'(pending), 32'(tbl[i].e_pend));
            chk($sformatf("tbl%0d_all_valid", i), 32'(all_valid), 32'(tbl[i].e_val));
            chk($sformatf("tbl%0d_overrun", i), 32'(overrun), 32'(tbl[i].e_ovr));
            chk($sformatf("tbl%0d_timeout", i), 32'(timeout), 32'(tbl[i].e_to));
        end

        // Backpressure with a pulse during HOLD.
        drive(1'b1, 1'b0, 8'hFF, 8'hFF, 1'b0); step();
        chk("bp_enter_valid", 32'(all_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0, 8'hFF, (k == 1) ? 8'h04 : 8'h00, 1'b0); step();
            chk("bp_hold_valid", 32'(all_valid), 32'd1);
            chk("bp_hold_pending", 32'(pending), 32'hFF);
        end
        chk("bp_overrun", 32'(overrun), 32'd1);
        drive(1'b1, 1'b0, 8'hFF, 8'h00, 1'b1); step();
        chk("bp_release_valid", 32'(all_valid), 32'd0);
        drive(1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1); step();
        drive(1'b1, 1'b0, 8'hFF, 8'h00, 1'b1); step();
        chk("bp_overrun_sticky", 32'(overrun), 32'd1);
        drive(1'b0, 1'b0, 8'hFF, 8'h00, 1'b0); step();
        chk("bp_overrun_reset", 32'(overrun), 32'd0);

        // Duplicate pulse within one round.
        drive(1'b1, 1'b0, 8'hFF, 8'h02, 1'b0); step();
        drive(1'b1, 1'b0, 8'hFF, 8'h02, 1'b0); step();
        chk("dup_overrun", 32'(overrun), 32'd1);
        chk("dup_pending_bit1", 32'(pending[1]), 32'd1);
        drive(1'b1, 1'b0, 8'hFF, 8'hFD, 1'b0); step();
        chk("dup_complete", 32'(all_valid), 32'd1);
        drive(1'b1, 1'b0, 8'hFF, 8'h00, 1'b1); step();

        // Timeout with limit 10: lanes 0-6 only, then lane 7.
        drive(1'b0, 1'b0, 8'hFF, 8'h00, 1'b0); step();
        timeout_limit = 16'd10;
        for (int k = 1; k <= 15; k++) begin
            drive(1'b1, 1'b0, 8'hFF, (k == 1) ? 8'h7F : 8'h00, 1'b0); step();
            chk($sformatf("to_cycle%0d", k), 32'(timeout), (k >= 10) ? 32'd1 : 32'd0);
        end
        drive(1'b1, 1'b0, 8'hFF, 8'h80, 1'b0); step();
        chk("to_late_valid", 32'(all_valid), 32'd1);
        chk("to_held_in_hold", 32'(timeout), 32'd1);
        drive(1'b1, 1'b0, 8'hFF, 8'h00, 1'b1); step();
        chk("to_cleared", 32'(timeout), 32'd0);

        // Limit 0 never times out.
        timeout_limit = 16'd0;
        drive(1'b1, 1'b0, 8'hFF, 8'h01, 1'b0); step();
        for (int k = 0; k < 1000; k++) begin
            drive(1'b1, 1'b0, 8'hFF, 8'h00, 1'b0); step();
        end
        chk("to_disabled", 32'(timeout), 32'd0);

        // Clear mid-round with pending=3C and overrun set.
        drive(1'b0, 1'b0, 8'hFF, 8'h00, 1'b0); step();
        timeout_limit = 16'd3;
        drive(1'b1, 1'b0, 8'hFF, 8'h04, 1'b0); step();
        drive(1'b1, 1'b0, 8'hFF, 8'h3C, 1'b0); step();
        drive(1'b1, 1'b0, 8'hFF, 8'h00, 1'b0); step();
        chk("clr_pre_pending", 32'(pending), 32'h3C);
        chk("clr_pre_timeout", 32'(timeout), 32'd1);
        drive(1'b1, 1'b1, 8'hFF, 8'h01, 1'b0); step();
        chk("clr_pending", 32'(pending), 32'h00);
        chk("clr_timeout", 32'(timeout), 32'd0);
        chk("clr_overrun_kept", 32'(overrun), 32'd1);
        chk("clr_valid", 32'(all_valid), 32'd0);

        // Reset while in HOLD.
        drive(1'b1, 1'b0, 8'hFF, 8'hFF, 1'b0); step();
        chk("rsthold_valid", 32'(all_valid), 32'd1);
        drive(1'b0, 1'b0, 8'hFF, 8'h00, 1'b0); step();
        chk("rsthold_outputs", {pending, all_valid, overrun, timeout}, 32'd0);

        // Randomized traffic; mask and limit change only at reset/clear.
        for (int k = 0; k < 3000; k++) begin
            int r;
            r = $urandom_range(0, 99);
            rst_n = (r != 0);
            clear = (r == 1 || r == 2);
            if (!rst_n || clear) begin
                lane_mask     = 8'($urandom);
                timeout_limit = 16'($urandom_range(0, 20));
            end
            r = $urandom_range(0, 9);
            if (r < 3) lane_done = 8'(1 << $urandom_range(0, 7));
            else if (r == 3) lane_done = 8'($urandom);
            else lane_done = 8'h00;
            all_ready = ($urandom_range(0, 2) != 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/done_barrier.md
Name: done_barrier

Overview:
- Join/barrier stage that collects per-lane single-cycle completion pulses into sticky bits.
- Reduces the sticky vector (with masked-off lanes forced to 1) through an AND chain, then raises a held "all done" handshake toward the consumer.
- Sits directly upstream of the team's AND-reduction logic: `pending` exposes the sticky vector so an external AND cascade can also consume it.
- Adds overrun and timeout detection for lanes that misbehave or never finish.

Parameters:
- LENGTH, 8, number of lanes (≥1).
- TIMEOUT_W, 16, width of the timeout counter and of `timeout_limit`.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- clear  input  1  synchronous abort; discards the current round.
- lane_mask  input  LENGTH  1 = lane participates; 0 = lane treated as done. Must be static within a round.
- lane_done  input  LENGTH  per-lane single-cycle completion pulse.
- pending  output  LENGTH  registered sticky done bits, raw and unmasked.
- all_valid  output  1  barrier complete, held until accepted.
- all_ready  input  1  consumer accepts the completion.
- overrun  output  1  sticky error flag: duplicate or out-of-round `lane_done`.
- timeout_limit  input  TIMEOUT_W  cycles allowed per round; 0 disables the timeout.
- timeout  output  1  level; round exceeded `timeout_limit`.

Behaviour:
- Reset (rst_n=0 at a clk edge) sets:
  - state=COLLECT, pending=0, all_valid=0, overrun=0, timeout=0, timeout counter=0.
  - Reset overrides every other input that cycle.
- Priority at each edge: reset > clear > handshake > collection.
- clear=1:
  - state=COLLECT, pending=0, all_valid=0, counter=0, timeout=0.
  - `overrun` is not cleared; only reset clears it.
  - `lane_done` in the same cycle is ignored.
- State COLLECT:
  - pending <= pending | lane_done.
  - If lane_done[i] & pending[i], set overrun <= 1. pending[i] stays 1.
  - eff = pending_next | ~lane_mask.
  - If the AND of all LENGTH bits of eff is 1: state <= HOLD, all_valid <= 1.
  - Latency: the final `lane_done` sampled at edge N gives all_valid=1 after edge N.
  - An all-zero `lane_mask` completes one cycle after COLLECT is entered.
- Timeout (COLLECT only):
  - The counter increments every cycle in COLLECT while not completing.
  - When counter == timeout_limit and timeout_limit != 0: timeout <= 1 and the counter saturates.
  - timeout stays 1 until round completion or clear. The round continues normally; it is not aborted.
- State HOLD:
  - all_valid stays 1 and `pending` is frozen until all_valid & all_ready at an edge.
  - On that handshake: pending <= 0, all_valid <= 0, counter <= 0, timeout <= 0, state <= COLLECT.
  - Any lane_done bit while in HOLD sets overrun <= 1 and is dropped. This includes the handshake cycle.
  - all_ready may be high before all_valid; the handshake completes on the first edge where both are 1. Minimum HOLD duration is 1 cycle.
- Back-to-back rounds: at most one round completes every 2 cycles (COLLECT then HOLD).
- Counter arithmetic:
  - Unsigned, TIMEOUT_W bits.
  - Saturates at timeout_limit; never wraps.
  - A limit of 2^TIMEOUT_W-1 is legal.
- All outputs are driven directly from registers; there is no combinational path from input to output.

Test Plan:
- Reset and in-order lanes:
  - Stimulus: reset, LENGTH=8, mask=FF, pulse lane_done=01,02,…,80 on consecutive cycles, all_ready=1.
  - Required: pending walks 01→03→…→FF; all_valid=1 exactly one cycle after the 80 pulse; handshake gives pending=00 and all_valid=0 the next cycle.
- Mask and simultaneous completion:
  - Stimulus: mask=0F, single pulse lane_done=0F.
  - Required: all_valid=1 next cycle, pending=0F.
  - Stimulus: mask=00.
  - Required: all_valid=1 one cycle after entering COLLECT, with no lane_done.
- Backpressure and overrun:
  - Stimulus: complete a round with all_ready=0 for 5 cycles, pulse lane_done=04 during HOLD, then all_ready=1.
  - Required: all_valid held 5+ cycles; pending frozen at FF; overrun=1 and stays 1 through later rounds until reset.
- Duplicate pulse:
  - Stimulus: lane_done=02 twice within one round.
  - Required: overrun=1; pending bit 1 remains 1; the round still completes normally.
- Timeout:
  - Stimulus: timeout_limit=10, mask=FF, pulse only lanes 0–6.
  - Required: timeout=1 after the 10th COLLECT cycle, stays 1. Lane 7 then pulses → all_valid=1; after the handshake timeout=0. timeout_limit=0 never asserts timeout over 1000 cycles.
- Clear and reset mid-round:
  - Stimulus: pending=3C, assert clear.
  - Required: pending=00, timeout=0, overrun unchanged, all_valid=0.
  - Stimulus: rst_n=0 during HOLD.
  - Required: every output is 0 after the edge.
